// File: rtl/and_gate.sv
// -----------------------------------------------------------------------------
// and_gate
//   Two-input AND primitive with a clocked observation wrapper. The y output is
//   purely combinational and independent of clk/rst. The clocked side registers
//   the result, flags 0->1 transitions of the registered value and, when the
//   AND_GATE_STATS_EN macro is defined, keeps two saturating activity counters.
//
//   Build option:
//     AND_GATE_STATS_EN  defined   -> cnt_high / cnt_rise counters are built
//                        undefined -> counters tied to 0, cnt_clr ignored
//
//   Ports:
//     clk       in   1      single clock, posedge
//     rst       in   1      synchronous, active-high reset
//     a, b      in   1      operands
//     y         out  1      combinational a & b
//     y_q       out  1      a & b registered once
//     y_rise    out  1      one-cycle pulse in the cycle y_q first reads 1
//     cnt_clr   in   1      synchronous counter clear (below rst in priority)
//     cnt_high  out  CNT_W  cycles with y_q==1, saturating
//     cnt_rise  out  CNT_W  number of y_rise pulses, saturating
// -----------------------------------------------------------------------------
module and_gate #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  output logic             y,
  output logic             y_q,
  input  logic             cnt_clr,
  output logic             y_rise,
  output logic [CNT_W-1:0] cnt_high,
  output logic [CNT_W-1:0] cnt_rise
);

  logic y_q_d;
  logic y_rise_d;
  logic y_rise_q;

  // Continuous assignment keeps Verilog & semantics for X/Z operands.
  assign y = a & b;

  always_comb begin
    y_q_d    = y;
    // y_q still holds the previous value here, so this flags the first 1.
    y_rise_d = y & ~y_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q      <= 1'b0;
      y_rise_q <= 1'b0;
    end else begin
      y_q      <= y_q_d;
      y_rise_q <= y_rise_d;
    end
  end

  assign y_rise = y_rise_q;

`ifdef AND_GATE_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_high_d;
  logic [CNT_W-1:0] cnt_high_q;
  logic [CNT_W-1:0] cnt_rise_d;
  logic [CNT_W-1:0] cnt_rise_q;

  // Counters observe the registered values, so they lag y_q/y_rise by a cycle.
  always_comb begin
    cnt_high_d = cnt_high_q;
    cnt_rise_d = cnt_rise_q;
    if (cnt_clr) begin
      cnt_high_d = '0;
      cnt_rise_d = '0;
    end else begin
      if (y_q && (cnt_high_q != CNT_MAX)) begin
        cnt_high_d = cnt_high_q + CNT_W'(1);
      end
      if (y_rise_q && (cnt_rise_q != CNT_MAX)) begin
        cnt_rise_d = cnt_rise_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_high_q <= '0;
      cnt_rise_q <= '0;
    end else begin
      cnt_high_q <= cnt_high_d;
      cnt_rise_q <= cnt_rise_d;
    end
  end

  assign cnt_high = cnt_high_q;
  assign cnt_rise = cnt_rise_q;
`else
  logic unused_cnt_clr;

  assign unused_cnt_clr = cnt_clr;
  assign cnt_high       = '0;
  assign cnt_rise       = '0;
`endif

endmodule

// File: tb/tb_and_gate.sv
// Bench for and_gate: combinational truth table with the clock stopped, then
// clocked sequences checked against a cycle model through a scoreboard queue,
// plus absolute checks at the corner cases. A second instance with CNT_W=2
// exercises counter saturation.
module tb_and_gate;

`ifdef AND_GATE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        clk_en = 1'b0;
  logic        rst = 1'b1;
  logic        a = 1'b0;
  logic        b = 1'b0;
  logic        cnt_clr = 1'b0;

  logic        y, y_q, y_rise;
  logic [15:0] cnt_high, cnt_rise;
  logic        y2, y_q2, y_rise2;
  logic [1:0]  cnt_high2, cnt_rise2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 if (clk_en) clk = ~clk;

  and_gate #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .y(y), .y_q(y_q), .cnt_clr(cnt_clr),
    .y_rise(y_rise), .cnt_high(cnt_high), .cnt_rise(cnt_rise)
  );

  and_gate #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .a(a), .b(b), .y(y2), .y_q(y_q2), .cnt_clr(cnt_clr),
    .y_rise(y_rise2), .cnt_high(cnt_high2), .cnt_rise(cnt_rise2)
  );

  typedef struct {
    logic a;
    logic b;
    logic y;
  } tt_t;

  typedef struct {
    logic rst;
    logic a;
    logic b;
    logic clr;
  } vec_t;

  typedef struct {
    int y;
    int yq;
    int rise;
    int hi;
    int ri;
    int hi2;
    int ri2;
  } exp_t;

  exp_t sb_q[$];

  // Reference model state
  int m_yq = 0, m_rise = 0, m_hi = 0, m_ri = 0, m_hi2 = 0, m_ri2 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sat_add(input int v, input int inc, input int maxv);
    return (v + inc > maxv) ? maxv : v + inc;
  endfunction

  // Drive one cycle of stimulus, advance the model, queue the expectation,
  // then compare once the DUT has taken the edge.
  task automatic step(input logic r, input logic ia, input logic ib, input logic clr);
    exp_t e;
    int   and_v;
    int   n_yq, n_rise, n_hi, n_ri, n_hi2, n_ri2;
    rst = r; a = ia; b = ib; cnt_clr = clr;
    and_v = (ia && ib) ? 1 : 0;
    if (r) begin
      n_yq = 0; n_rise = 0; n_hi = 0; n_ri = 0; n_hi2 = 0; n_ri2 = 0;
    end else begin
      n_yq   = and_v;
      n_rise = (and_v == 1 && m_yq == 0) ? 1 : 0;
      if (!STATS || clr) begin
        n_hi = 0; n_ri = 0; n_hi2 = 0; n_ri2 = 0;
      end else begin
        n_hi  = sat_add(m_hi,  m_yq,   65535);
        n_ri  = sat_add(m_ri,  m_rise, 65535);
        n_hi2 = sat_add(m_hi2, m_yq,   3);
        n_ri2 = sat_add(m_ri2, m_rise, 3);
      end
    end
    m_yq = n_yq; m_rise = n_rise; m_hi = n_hi; m_ri = n_ri; m_hi2 = n_hi2; m_ri2 = n_ri2;
    e.y = and_v; e.yq = n_yq; e.rise = n_rise;
    e.hi = n_hi; e.ri = n_ri; e.hi2 = n_hi2; e.ri2 = n_ri2;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check("y",         32'(y),         32'(e.y));
      check("y_q",       32'(y_q),       32'(e.yq));
      check("y_rise",    32'(y_rise),    32'(e.rise));
      check("cnt_high",  32'(cnt_high),  32'(e.hi));
      check("cnt_rise",  32'(cnt_rise),  32'(e.ri));
      check("cnt_high2", 32'(cnt_high2), 32'(e.hi2));
      check("cnt_rise2", 32'(cnt_rise2), 32'(e.ri2));
      check("y_q2",      32'(y_q2),      32'(e.yq));
      check("y_rise2",   32'(y_rise2),   32'(e.rise));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    tt_t  tt[4];
    vec_t mix[14];

    tt[0] = '{1'b0, 1'b0, 1'b0};
    tt[1] = '{1'b0, 1'b1, 1'b0};
    tt[2] = '{1'b1, 1'b0, 1'b0};
    tt[3] = '{1'b1, 1'b1, 1'b1};

    mix[0]  = '{1'b0, 1'b1, 1'b0, 1'b0};
    mix[1]  = '{1'b0, 1'b1, 1'b1, 1'b0};
    mix[2]  = '{1'b0, 1'b1, 1'b1, 1'b0};
    mix[3]  = '{1'b0, 1'b0, 1'b1, 1'b0};
    mix[4]  = '{1'b0, 1'b1, 1'b1, 1'b0};
    mix[5]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    mix[6]  = '{1'b0, 1'b1, 1'b1, 1'b0};
    mix[7]  = '{1'b0, 1'b1, 1'b1, 1'b1};
    mix[8]  = '{1'b0, 1'b0, 1'b0, 1'b0};
    mix[9]  = '{1'b0, 1'b1, 1'b1, 1'b0};
    mix[10] = '{1'b0, 1'b1, 1'b1, 1'b0};
    mix[11] = '{1'b0, 1'b0, 1'b0, 1'b1};
    mix[12] = '{1'b0, 1'b1, 1'b1, 1'b0};
    mix[13] = '{1'b0, 1'b1, 1'b1, 1'b0};

    // Truth table with the clock stopped
    for (int i = 0; i < 4; i++) begin
      a = tt[i].a; b = tt[i].b;
      #10;
      check("truth_y", 32'(y), 32'(tt[i].y));
    end

    clk_en = 1'b1;

    // Reset held for two edges with y=1
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check("rst_y_high", 32'(y), 32'd1);
    check("rst_y_q", 32'(y_q), 32'd0);

    // Release with a=b=1: y_q and y_rise both rise on the first edge
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check("edge1_y_rise", 32'(y_rise), 32'd1);
    check("edge1_y_q", 32'(y_q), 32'd1);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check("edge2_y_rise", 32'(y_rise), 32'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check("edge4_cnt_high", 32'(cnt_high), STATS ? 32'd3 : 32'd0);
    check("edge4_cnt_rise", 32'(cnt_rise), STATS ? 32'd1 : 32'd0);

    // Hold high long enough to saturate the 2-bit instance
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    check("sat_cnt_high2", 32'(cnt_high2), STATS ? 32'd3 : 32'd0);
    check("hold_cnt_high", 32'(cnt_high), STATS ? 32'd13 : 32'd0);

    // Five rising edges of y; the 2-bit rise counter saturates
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b0);
    end
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check("sat_cnt_rise2", 32'(cnt_rise2), STATS ? 32'd3 : 32'd0);
    check("toggle_cnt_rise", 32'(cnt_rise), STATS ? 32'd6 : 32'd0);

    // Clear while y_q=1, then counting resumes
    step(1'b0, 1'b1, 1'b1, 1'b1);
    check("clr_cnt_high", 32'(cnt_high), 32'd0);
    check("clr_cnt_rise", 32'(cnt_rise), 32'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check("resume_cnt_high", 32'(cnt_high), STATS ? 32'd1 : 32'd0);

    // Reset and clear together
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    check("rstclr_y_q", 32'(y_q), 32'd0);
    check("rstclr_cnt_high", 32'(cnt_high), 32'd0);

    // Mixed table, including a mid-activity reset
    for (int i = 0; i < 14; i++) step(mix[i].rst, mix[i].a, mix[i].b, mix[i].clr);

    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
